// File: rtl/rtc_pkg.sv
// Shared definitions for the 3-wire RTC byte-transaction engine:
// FSM state encoding, device register map, command byte layout.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT   = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } rtc_state_t;

    // Clock/calendar register addresses
    localparam logic [4:0] SEC  = 5'd0;
    localparam logic [4:0] MIN  = 5'd1;
    localparam logic [4:0] HR   = 5'd2;
    localparam logic [4:0] DATE = 5'd3;
    localparam logic [4:0] MON  = 5'd4;
    localparam logic [4:0] DAY  = 5'd5;
    localparam logic [4:0] YEAR = 5'd6;
    localparam logic [4:0] WP   = 5'd7;

    // Command byte bit positions
    localparam int CMD_RW_BIT    = 0;   // 1 = read, 0 = write
    localparam int CMD_ADDR_LSB  = 1;   // 5-bit address field
    localparam int CMD_RAM_BIT   = 6;   // 1 = RAM space
    localparam int CMD_FIXED_BIT = 7;   // always 1

    // Bus framing
    localparam int BIT_TIMES = 16;

    // Assemble the command byte sent in bit-times 0..7
    function automatic logic [7:0] build_cmd(input logic       ram,
                                             input logic [4:0] addr,
                                             input logic       write);
        logic [7:0] cmd;
        cmd                          = '0;
        cmd[CMD_FIXED_BIT]           = 1'b1;
        cmd[CMD_RAM_BIT]             = ram;
        cmd[CMD_ADDR_LSB +: 5]       = addr;
        cmd[CMD_RW_BIT]              = ~write;
        return cmd;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// SCK phase timer: counts CLK_DIV clk cycles per phase and flags the
// last cycle of each phase. A clear restarts the count on state entry.
module rtc_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic phase_end
);

    localparam int                CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Phase counter: wraps at each phase end, restarts on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign phase_end = (cnt == LAST);

endmodule

// File: rtl/rtc_3wire_engine.sv
// DS1302-style 3-wire bus engine. Accepts one command per handshake,
// drives the CE/SCK/IO waveform LSB first (8 command bits then 8 data
// bits) and returns the read byte with a one-cycle response strobe.
// All outputs are registered from the next-state values so they line up
// with the state they describe.
module rtc_3wire_engine
    import rtc_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int GAP     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_ram,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       CE,
    output logic       SCK,
    output logic       io_out,
    output logic       io_oe,
    input  logic       io_in
);

    localparam int               GAP_W    = $clog2(GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    rtc_state_t       state, state_nxt;
    logic             ph, ph_nxt;             // 0 = SCK low phase, 1 = high phase
    logic [3:0]       bit_cnt, bit_nxt;       // bit-time 0..15
    logic             is_wr, is_wr_nxt;
    logic [15:0]      tx_reg, tx_nxt;         // {write data, command}
    logic [7:0]       shift_reg;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_done;
    logic             phase_end;
    logic             phase_clr;
    logic             accept;

    logic ce_d, sck_d, io_out_d, io_oe_d, rsp_valid_d, busy_d, ready_d;
    logic rd_done;

    assign accept    = req_valid && req_ready;
    assign gap_done  = (gap_cnt == GAP_LAST);
    assign phase_clr = (state_nxt != state) || (state == IDLE);
    assign rd_done   = (state == HOLD) && (state_nxt == RECOVER) && !is_wr;

    rtc_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (phase_clr),
        .phase_end (phase_end)
    );

    // State register and sequencing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ph      <= 1'b0;
            bit_cnt <= '0;
            is_wr   <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            ph      <= ph_nxt;
            bit_cnt <= bit_nxt;
            is_wr   <= is_wr_nxt;
            gap_cnt <= (state == RECOVER && !gap_done) ? gap_cnt + 1'b1 : '0;
        end
    end

    // Next-state logic: FSM transitions, phase/bit stepping, command capture
    always_comb begin
        state_nxt = state;
        ph_nxt    = 1'b0;
        bit_nxt   = '0;
        is_wr_nxt = accept ? req_write : is_wr;
        tx_nxt    = accept ? {(req_write ? req_wdata : 8'h00),
                              build_cmd(req_ram, req_addr, req_write)}
                           : tx_reg;
        case (state)
            IDLE:    if (accept)    state_nxt = SETUP;
            SETUP:   if (phase_end) state_nxt = SHIFT;
            SHIFT: begin
                ph_nxt  = phase_end ? ~ph : ph;
                bit_nxt = (phase_end && ph) ? bit_cnt + 4'd1 : bit_cnt;
                if (phase_end && ph && bit_cnt == 4'(BIT_TIMES - 1)) begin
                    state_nxt = HOLD;
                    ph_nxt    = 1'b0;
                    bit_nxt   = '0;
                end
            end
            HOLD:    if (phase_end) state_nxt = RECOVER;
            RECOVER: if (gap_done)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state; bit index only moves at a low-phase start
    always_comb begin
        ce_d     = 1'b0;
        sck_d    = 1'b0;
        io_out_d = 1'b0;
        io_oe_d  = 1'b0;
        case (state_nxt)
            SETUP: begin
                ce_d     = 1'b1;
                io_out_d = tx_nxt[0];
                io_oe_d  = 1'b1;
            end
            SHIFT: begin
                ce_d     = 1'b1;
                sck_d    = ph_nxt;
                io_out_d = tx_nxt[bit_nxt];
                // reads release the line once the data byte starts
                io_oe_d  = is_wr_nxt || !bit_nxt[3];
            end
            HOLD:    ce_d = 1'b1;
            default: ce_d = 1'b0;
        endcase
        rsp_valid_d = (state == HOLD) && (state_nxt == RECOVER);
        busy_d      = (state_nxt != IDLE);
        ready_d     = (state_nxt == IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CE        <= 1'b0;
            SCK       <= 1'b0;
            io_out    <= 1'b0;
            io_oe     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            CE        <= ce_d;
            SCK       <= sck_d;
            io_out    <= io_out_d;
            io_oe     <= io_oe_d;
            rsp_valid <= rsp_valid_d;
            busy      <= busy_d;
            req_ready <= ready_d;
            if (rd_done) begin
                rsp_rdata <= shift_reg;
            end
        end
    end

    // Transmit frame holds the captured command and write data
    always_ff @(posedge clk) begin
        tx_reg <= tx_nxt;
    end

    // Read sampling on the last cycle of each data-bit low phase
    always_ff @(posedge clk) begin
        if (state == SHIFT && !ph && phase_end && bit_cnt[3]) begin
            shift_reg[bit_cnt[2:0]] <= io_in;
        end
    end

endmodule

// File: tb/tb_rtc_3wire_engine.sv
// Bench for rtc_3wire_engine: two instances (CLK_DIV=2 and CLK_DIV=1)
// talking to a behavioural DS1302 device model.
module tb_rtc_3wire_engine;
    import rtc_pkg::*;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic       req_write = 1'b0;
    logic       req_ram = 1'b0;
    logic [4:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic [1:0] rsp_valid, busy, ce, sck, io_out, io_oe;
    logic [1:0] io_in = '0;
    logic [7:0] rdata0, rdata1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rd [2];

    always #5 clk = ~clk;

    rtc_3wire_engine #(.CLK_DIV(2), .GAP(GAP)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_ram(req_ram), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata0), .busy(busy[0]), .CE(ce[0]),
        .SCK(sck[0]), .io_out(io_out[0]), .io_oe(io_oe[0]), .io_in(io_in[0]));

    rtc_3wire_engine #(.CLK_DIV(1), .GAP(GAP)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_ram(req_ram), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata1), .busy(busy[1]), .CE(ce[1]),
        .SCK(sck[1]), .io_out(io_out[1]), .io_oe(io_oe[1]), .io_in(io_in[1]));

    // Device model: latches IO on SCK rise, drives read data after the 8th fall
    logic [1:0]  ce_q = '0;
    logic [1:0]  sck_q = '0;
    int          rise_n [2] = '{0, 0};
    int          fall_n [2] = '{0, 0};
    int          sck_total [2] = '{0, 0};
    logic [15:0] rx [2] = '{16'h0, 16'h0};
    logic [7:0]  dev_byte [2] = '{8'h0, 8'h0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ce[i] && !ce_q[i]) begin
                rise_n[i] = 0;
                fall_n[i] = 0;
                rx[i]     = '0;
                io_in[i]  = 1'b0;
            end
            if (sck[i] && !sck_q[i]) begin
                sck_total[i]++;
                if (rise_n[i] < 16) rx[i][rise_n[i][3:0]] = io_out[i];
                rise_n[i]++;
            end
            if (!sck[i] && sck_q[i]) begin
                fall_n[i]++;
                if (fall_n[i] >= 8 && fall_n[i] <= 15 && rx[i][0])
                    io_in[i] = dev_byte[i][3'(fall_n[i] - 8)];
            end
            ce_q[i]  = ce[i];
            sck_q[i] = sck[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_of(input int i);
        return (i == 0) ? rdata0 : rdata1;
    endfunction

    // Expected waveform as a function of cycle k after the accepting edge
    function automatic bit exp_ce(input int k, input int h);
        return (k >= 1) && (k <= 34 * h);
    endfunction

    function automatic bit exp_sck(input int k, input int h);
        if (k <= h || k > 33 * h) return 1'b0;
        return ((k - h - 1) % (2 * h)) >= h;
    endfunction

    function automatic bit exp_oe(input int k, input int h, input bit wr);
        if (k < 1 || k > 33 * h) return 1'b0;
        if (k <= h) return 1'b1;
        return wr ? 1'b1 : (((k - h - 1) / (2 * h)) < 8);
    endfunction

    task automatic run_txn(input int i, input int h, input bit wr, input bit ram,
                           input logic [4:0] addr, input logic [7:0] wd, input logic [7:0] dv,
                           input bit hold, input bit perturb, input string tag);
        logic [7:0] exp_cmd;
        int t, lim, ce_n, vld_n, vld_k, bad_ce, bad_sck, bad_oe, bad_busy;
        bit e_busy;
        exp_cmd = 8'h80 | (8'(ram) << 6) | (8'(addr) << 1) | 8'(!wr);
        lim = 34 * h + GAP + 1;
        dev_byte[i] = dv;
        req_write = wr; req_ram = ram; req_addr = addr; req_wdata = wd;
        req_valid[i] = 1'b1;
        t = 0;
        while (req_ready[i] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_accept"}, 32'(t < 200), 32'd1);
        if (t >= 200) begin
            req_valid[i] = 1'b0;
            return;
        end
        ce_n = 0; vld_n = 0; vld_k = -1;
        bad_ce = 0; bad_sck = 0; bad_oe = 0; bad_busy = 0;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid[i] = 1'b0;
            if (perturb && k == 20) begin
                req_write = 1'($urandom); req_ram = 1'($urandom);
                req_addr = 5'($urandom); req_wdata = 8'($urandom);
            end
            e_busy = (k <= 34 * h + GAP);
            if (ce[i] === 1'b1) ce_n++;
            if (ce[i] !== exp_ce(k, h)) bad_ce++;
            if (sck[i] !== exp_sck(k, h)) bad_sck++;
            if (io_oe[i] !== exp_oe(k, h, wr)) bad_oe++;
            if (busy[i] !== e_busy || req_ready[i] !== !e_busy) bad_busy++;
            if (rsp_valid[i] === 1'b1) begin
                vld_n++;
                vld_k = k;
            end
        end
        if (!wr) exp_rd[i] = dv;
        check({tag, "_ce_len"}, ce_n, 34 * h);
        check({tag, "_ce_shape"}, bad_ce, 0);
        check({tag, "_sck_shape"}, bad_sck, 0);
        check({tag, "_oe_shape"}, bad_oe, 0);
        check({tag, "_busy_ready"}, bad_busy, 0);
        check({tag, "_vld_count"}, vld_n, 1);
        check({tag, "_vld_cycle"}, vld_k, 34 * h + 1);
        check({tag, "_sck_rises"}, rise_n[i], 16);
        check({tag, "_cmd"}, rx[i][7:0], exp_cmd);
        if (wr) check({tag, "_wdata"}, rx[i][15:8], wd);
        check({tag, "_rdata"}, rd_of(i), exp_rd[i]);
    endtask

    initial begin
        int tot0, tot1, vld_n, ce_n;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;

        // Reset and idle behaviour
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ce", ce, 2'b00);
        check("rst_sck", sck, 2'b00);
        check("rst_io_out", io_out, 2'b00);
        check("rst_io_oe", io_oe, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_busy", busy, 2'b00);
        check("rst_ready", req_ready, 2'b11);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_rdata1", rdata1, 8'h00);
        tot0 = sck_total[0];
        tot1 = sck_total[1];
        repeat (20) @(negedge clk);
        check("idle_sck0", sck_total[0], tot0);
        check("idle_sck1", sck_total[1], tot1);

        // Directed transactions on the CLK_DIV=2 instance
        run_txn(0, 2, 1'b0, 1'b0, SEC, 8'h00, 8'h59, 1'b0, 1'b0, "rd_sec");
        run_txn(0, 2, 1'b1, 1'b0, WP, 8'h00, 8'hFF, 1'b0, 1'b0, "wr_wp");
        run_txn(0, 2, 1'b0, 1'b0, MIN, 8'h00, 8'h37, 1'b1, 1'b1, "b2b_min");
        run_txn(0, 2, 1'b0, 1'b0, SEC, 8'h00, 8'hC4, 1'b0, 1'b1, "b2b_sec");

        // Randomized transactions
        for (int n = 0; n < 6; n++) begin
            run_txn(0, 2, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom),
                    8'($urandom), 1'b0, 1'b0, $sformatf("rnd%0d", n));
        end

        // CLK_DIV=1 instance
        run_txn(1, 1, 1'b0, 1'b0, SEC, 8'h00, 8'h12, 1'b0, 1'b0, "h1_rd");
        run_txn(1, 1, 1'b1, 1'b1, 5'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0, "h1_wr");
        run_txn(1, 1, 1'b0, 1'b1, 5'($urandom), 8'h00, 8'($urandom), 1'b0, 1'b0, "h1_rd2");

        // Reset during bit-time 5 of a read
        dev_byte[0] = 8'hA5;
        req_write = 1'b0; req_ram = 1'b0; req_addr = HR; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (24) @(negedge clk);
        check("mid_sck_high", sck[0], 1'b1);
        rst_n = 1'b0;
        #1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        check("mid_rst_ce", ce[0], 1'b0);
        check("mid_rst_sck", sck[0], 1'b0);
        check("mid_rst_oe", io_oe[0], 1'b0);
        check("mid_rst_rdata", rdata0, exp_rd[0]);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vld_n = 0;
        ce_n = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) vld_n++;
            if (ce[0] === 1'b1) ce_n++;
        end
        check("post_rst_vld", vld_n, 0);
        check("post_rst_ce", ce_n, 0);
        check("post_rst_ready", req_ready[0], 1'b1);
        run_txn(0, 2, 1'b0, 1'b1, 5'd31, 8'h00, 8'h3C, 1'b0, 1'b0, "post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
